// File: rtl/cmd_processor_n.sv
// Serial command processor: decodes single-byte commands with optional
// argument bytes, drives trigger timing / PLL controls and streams
// histogram snapshots and status bytes back to the UART transmitter.
module cmd_processor_n #(
    parameter int         NCH     = 4,
    parameter int         HW      = 32,
    parameter int         TIMEOUT = 1000000,
    parameter logic [7:0] FWVER   = 8'd2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxReady,
    input  logic [7:0]        rxData,
    input  logic              txBusy,
    output logic              txStart,
    output logic [7:0]        txData,
    input  logic [NCH*HW-1:0] histos,
    output logic              resethist,
    output logic [7:0]        deadticks,
    output logic [7:0]        firingticks,
    output logic              enable_outputs,
    output logic [2:0]        phasecounterselect,
    output logic              phaseupdown,
    output logic              phasestep,
    output logic              scanclk,
    output logic              clkswitch
);

    localparam int          NB   = NCH * HW / 8;
    localparam int          HB   = HW / 8;
    localparam int          BB   = (NB > 3) ? NB : 3;
    localparam logic [31:0] TMO  = 32'(TIMEOUT);
    localparam logic [7:0]  NCH8 = 8'(NCH);

    typedef enum logic [2:0] {IDLE, ARGS, EXEC, CLKSW, PHASE, TXLOAD, TXWAIT} state_t;

    state_t          state;
    logic [7:0]      cmd;
    logic [7:0]      arg;
    logic [31:0]     tcnt;
    logic [6:0]      pc;
    logic [3:0]      steps;
    logic [BB*8-1:0] buffer;
    logic [6:0]      idx;
    logic [6:0]      last;
    logic            wait1;
    logic            overrun;

    // Commands that consume one argument byte before execution.
    function automatic logic needs_arg(input logic [7:0] c);
        return (c == 8'd1) || (c == 8'd2) || (c == 8'd5) || (c == 8'd13);
    endfunction

    // Command FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cmd                <= '0;
            arg                <= '0;
            tcnt               <= '0;
            pc                 <= '0;
            steps              <= '0;
            buffer             <= '0;
            idx                <= '0;
            last               <= '0;
            wait1              <= 1'b0;
            overrun            <= 1'b0;
            txStart            <= 1'b0;
            txData             <= '0;
            resethist          <= 1'b0;
            deadticks          <= 8'd10;
            firingticks        <= 8'd9;
            enable_outputs     <= 1'b0;
            phasecounterselect <= '0;
            phaseupdown        <= 1'b1;
            phasestep          <= 1'b0;
            scanclk            <= 1'b0;
            clkswitch          <= 1'b0;
        end else begin
            txStart   <= 1'b0;
            resethist <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxReady) begin
                        cmd  <= rxData;
                        tcnt <= '0;
                        if (needs_arg(rxData)) begin
                            state <= ARGS;
                        end else begin
                            state <= EXEC;
                            // resethist is raised on entry so it is high during EXEC,
                            // the same cycle whose closing edge takes the snapshot.
                            if (rxData == 8'd10) resethist <= 1'b1;
                        end
                    end
                end
                ARGS: begin
                    if (rxReady) begin
                        arg   <= rxData;
                        state <= EXEC;
                        if (cmd == 8'd13 && rxData < NCH8) resethist <= 1'b1;
                    end else if (tcnt == TMO) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                EXEC: begin
                    idx   <= '0;
                    wait1 <= 1'b0;
                    state <= IDLE;
                    case (cmd)
                        8'd0: begin
                            buffer <= {{(BB*8-8){1'b0}}, FWVER};
                            last   <= 7'd0;
                            state  <= TXLOAD;
                        end
                        8'd1: deadticks      <= arg;
                        8'd2: firingticks    <= arg;
                        8'd3: enable_outputs <= ~enable_outputs;
                        8'd4: begin
                            clkswitch <= 1'b1;
                            tcnt      <= '0;
                            state     <= CLKSW;
                        end
                        8'd5: begin
                            phasecounterselect <= arg[2:0];
                            phaseupdown        <= arg[3];
                            steps              <= (arg[7:4] == 4'd0) ? 4'd1 : arg[7:4];
                            pc                 <= '0;
                            phasestep          <= 1'b1;
                            scanclk            <= 1'b0;
                            state              <= PHASE;
                        end
                        8'd9: phaseupdown <= ~phaseupdown;
                        8'd10: begin
                            buffer              <= '0;
                            buffer[NCH*HW-1:0]  <= histos;
                            last                <= 7'(NB - 1);
                            state               <= TXLOAD;
                        end
                        8'd13: begin
                            buffer <= '0;
                            if (arg < NCH8) begin
                                buffer[HW-1:0] <= histos[arg[3:0]*HW +: HW];
                                last           <= 7'(HB - 1);
                            end else begin
                                buffer[7:0] <= 8'hFF;
                                last        <= 7'd0;
                            end
                            state <= TXLOAD;
                        end
                        8'd14: begin
                            buffer        <= '0;
                            buffer[23:0]  <= {overrun, 2'b00, enable_outputs, phaseupdown,
                                              phasecounterselect, firingticks, deadticks};
                            last          <= 7'd2;
                            state         <= TXLOAD;
                        end
                        default: state <= IDLE;
                    endcase
                end
                CLKSW: begin
                    if (tcnt == 32'd7) begin
                        clkswitch <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                PHASE: begin
                    pc <= pc + 7'd1;
                    if (pc[3:0] == 4'hF) scanclk <= ~scanclk;
                    if (pc == 7'd95) phasestep <= 1'b0;
                    if (pc == 7'd127) begin
                        if (steps == 4'd1) begin
                            state <= IDLE;
                        end else begin
                            steps     <= steps - 4'd1;
                            phasestep <= 1'b1;
                        end
                    end
                end
                TXLOAD: begin
                    if (!txBusy) begin
                        txStart <= 1'b1;
                        txData  <= buffer[{idx, 3'b000} +: 8];
                        wait1   <= 1'b1;
                        state   <= TXWAIT;
                    end
                end
                TXWAIT: begin
                    if (wait1) begin
                        wait1 <= 1'b0;
                    end else if (!txBusy) begin
                        if (idx == last) begin
                            state <= IDLE;
                            if (cmd == 8'd14) overrun <= 1'b0;
                        end else begin
                            idx   <= idx + 7'd1;
                            state <= TXLOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (rxReady && (state inside {EXEC, CLKSW, PHASE, TXLOAD, TXWAIT})) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_processor_n.sv
// Self-checking bench for cmd_processor_n with a byte-level reference model.
module tb_cmd_processor_n;
    localparam int         NCH = 4;
    localparam int         HW  = 32;
    localparam int         HB  = HW / 8;
    localparam int         TMO = 200;
    localparam logic [7:0] FW  = 8'h5A;

    logic              clk = 1'b0;
    logic              reset;
    logic              rxReady;
    logic [7:0]        rxData;
    logic              txBusy;
    logic              txStart;
    logic [7:0]        txData;
    logic [NCH*HW-1:0] histos;
    logic              resethist;
    logic [7:0]        deadticks;
    logic [7:0]        firingticks;
    logic              enable_outputs;
    logic [2:0]        phasecounterselect;
    logic              phaseupdown;
    logic              phasestep;
    logic              scanclk;
    logic              clkswitch;

    cmd_processor_n #(.NCH(NCH), .HW(HW), .TIMEOUT(TMO), .FWVER(FW)) dut (
        .clk(clk), .reset(reset), .rxReady(rxReady), .rxData(rxData),
        .txBusy(txBusy), .txStart(txStart), .txData(txData), .histos(histos),
        .resethist(resethist), .deadticks(deadticks), .firingticks(firingticks),
        .enable_outputs(enable_outputs), .phasecounterselect(phasecounterselect),
        .phaseupdown(phaseupdown), .phasestep(phasestep), .scanclk(scanclk),
        .clkswitch(clkswitch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // observation counters, written only by the monitor
    logic [7:0] txb [4096];
    int wr = 0, cyc = 0, n_rh = 0, n_cs = 0, n_ps = 0, n_psh = 0, n_sc = 0, last_tog = 0;
    logic ps_prev = 1'b0, sc_prev = 1'b0;

    // reference model state
    logic [7:0]  m_dead, m_fire;
    logic        m_en, m_ud, m_ovr;
    logic [2:0]  m_sel;
    logic [31:0] h [NCH];
    logic [7:0]  eq [$];
    int rd = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (txStart === 1'b1 && wr < 4096) begin txb[wr] = txData; wr++; end
        if (resethist === 1'b1) n_rh++;
        if (clkswitch === 1'b1) n_cs++;
        if (phasestep === 1'b1) n_psh++;
        if (phasestep === 1'b1 && ps_prev !== 1'b1) n_ps++;
        if (scanclk !== sc_prev) begin n_sc++; last_tog = cyc; end
        ps_prev = phasestep;
        sc_prev = scanclk;
    end

    // transmitter model: busy for a random number of cycles after each txStart
    initial begin
        txBusy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (txStart === 1'b1) begin
                txBusy = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                txBusy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rxReady = 1'b1; rxData = b;
        @(negedge clk); rxReady = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; rxReady = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        m_dead = 8'd10; m_fire = 8'd9; m_en = 1'b0; m_ud = 1'b1; m_sel = 3'd0; m_ovr = 1'b0;
    endtask

    function automatic logic [7:0] status_byte();
        return {m_ovr, 2'b00, m_en, m_ud, m_sel};
    endfunction

    function automatic logic [NCH*HW-1:0] pack_h();
        logic [NCH*HW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*HW +: HW] = h[c];
        return v;
    endfunction

    // wait (bounded) for the expected bytes, allow extra ones to show up, then compare
    task automatic expect_bytes(input string tag);
        int budget = 0;
        while ((wr - rd) < eq.size() && budget < 3000) begin @(negedge clk); budget++; end
        wait_cycles(30);
        chk({tag, "_count"}, 32'(wr - rd), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (rd + i < wr) ? {24'd0, txb[rd + i]} : 'x, {24'd0, eq[i]});
        rd = wr;
    endtask

    task automatic expect_status(input string tag);
        eq = {};
        eq.push_back(m_dead); eq.push_back(m_fire); eq.push_back(status_byte());
        send_byte(8'h0E);
        expect_bytes(tag);
        m_ovr = 1'b0;
    endtask

    task automatic expect_dump(input string tag, input int ch);
        int base = n_rh;
        eq = {};
        if (ch < 0) begin
            for (int k = 0; k < NCH*HB; k++) eq.push_back(8'(h[k / HB] >> (8 * (k % HB))));
            send_byte(8'h0A);
        end else begin
            if (ch < NCH) for (int k = 0; k < HB; k++) eq.push_back(8'(h[ch] >> (8 * k)));
            else eq.push_back(8'hFF);
            send_byte(8'h0D);
            send_byte(8'(ch));
        end
        @(negedge clk);
        for (int c = 0; c < NCH; c++) h[c] = $urandom;   // must not affect bytes in flight
        histos = pack_h();
        expect_bytes(tag);
        chk({tag, "_resethist"}, 32'(n_rh - base), (ch < NCH) ? 32'd1 : 32'd0);
    endtask

    task automatic run_phase(input string tag, input logic [7:0] a, input logic ovr_byte);
        int s, b_ps, b_psh, b_sc, t0;
        s = (a[7:4] == 4'd0) ? 1 : int'(a[7:4]);
        b_ps = n_ps; b_psh = n_psh; b_sc = n_sc;
        send_byte(8'h05);
        send_byte(a);
        t0 = cyc;
        m_sel = a[2:0]; m_ud = a[3];
        @(negedge clk);
        chk({tag, "_sel"}, 32'(phasecounterselect), 32'(m_sel));
        chk({tag, "_ud"}, 32'(phaseupdown), 32'(m_ud));
        if (ovr_byte) begin
            wait_cycles(60);
            send_byte(8'h00);
            m_ovr = 1'b1;
        end
        while (cyc < t0 + 128 * s + 20) @(negedge clk);
        chk({tag, "_steps"}, 32'(n_ps - b_ps), 32'(s));
        chk({tag, "_stephigh"}, 32'(n_psh - b_psh), 32'(96 * s));
        chk({tag, "_toggles"}, 32'(n_sc - b_sc), 32'(8 * s));
        chk({tag, "_duration"}, 32'(last_tog - t0), 32'(1 + 128 * s));
        chk({tag, "_scanclk_end"}, 32'(scanclk), 32'd0);
    endtask

    initial begin
        int b, c;
        logic [7:0] a;
        reset = 1'b1; rxReady = 1'b0; rxData = '0; histos = '0;
        for (int i = 0; i < NCH; i++) h[i] = '0;
        wait_cycles(3);
        chk("rst_txStart", 32'(txStart), 32'd0);
        chk("rst_txData", 32'(txData), 32'd0);
        chk("rst_resethist", 32'(resethist), 32'd0);
        chk("rst_dead", 32'(deadticks), 32'd10);
        chk("rst_fire", 32'(firingticks), 32'd9);
        chk("rst_pll", {27'd0, enable_outputs, phaseupdown, phasestep, scanclk, clkswitch}, 32'b01000);
        chk("rst_sel", 32'(phasecounterselect), 32'd0);
        do_reset();

        eq = {}; eq.push_back(FW);
        send_byte(8'h00);
        expect_bytes("fwver");

        send_byte(8'h01); send_byte(8'h2A);
        chk("dead_before_exec", 32'(deadticks), 32'd10);
        @(negedge clk);
        m_dead = 8'h2A;
        chk("dead_at_exec", 32'(deadticks), 32'h2A);
        expect_status("status1");

        for (int i = 0; i < 6; i++) begin
            c = $urandom_range(0, 3);
            a = 8'($urandom);
            case (c)
                0: begin send_byte(8'h01); send_byte(a); m_dead = a; end
                1: begin send_byte(8'h02); send_byte(a); m_fire = a; end
                2: begin send_byte(8'h03); m_en = ~m_en; end
                default: begin send_byte(8'h09); m_ud = ~m_ud; end
            endcase
            wait_cycles(3);
            chk($sformatf("regs%0d", i),
                {14'd0, deadticks, firingticks, enable_outputs, phaseupdown},
                {14'd0, m_dead, m_fire, m_en, m_ud});
        end
        expect_status("status_rand");

        eq = {};
        send_byte(8'h07);
        expect_bytes("ignored");

        h[3] = 32'h44332211; h[2] = 32'h88776655; h[1] = 32'hCCBBAA99; h[0] = 32'h00FFEEDD;
        histos = pack_h();
        expect_dump("dump_dir", -1);
        for (int i = 0; i < NCH; i++) h[i] = $urandom;
        histos = pack_h();
        expect_dump("dump_rand", -1);

        h[3] = 32'h44332211; h[2] = 32'h88776655; h[1] = 32'hCCBBAA99; h[0] = 32'h00FFEEDD;
        histos = pack_h();
        expect_dump("ch2", 2);
        expect_dump("ch3", NCH - 1);
        expect_dump("ch_bad7", 7);
        expect_dump("ch_bad4", NCH);
        expect_dump("ch_rand", int'($urandom_range(0, NCH - 1)));

        b = n_cs;
        send_byte(8'h04);
        wait_cycles(20);
        chk("clkswitch_cycles", 32'(n_cs - b), 32'd8);

        run_phase("phase3b", 8'h3B, 1'b1);
        expect_status("status_ovr");
        expect_status("status_ovr_clr");
        run_phase("phase_s0", {4'd0, 4'($urandom)}, 1'b0);
        run_phase("phase_rand", {4'($urandom_range(1, 2)), 4'($urandom)}, 1'b0);

        send_byte(8'h02);
        wait_cycles(TMO + 20);
        eq = {}; eq.push_back(FW);
        send_byte(8'h00);
        expect_bytes("timeout_fw");
        chk("timeout_fire", 32'(firingticks), 32'(m_fire));
        send_byte(8'h02);
        wait_cycles(TMO - 10);
        send_byte(8'h77);
        m_fire = 8'h77;
        wait_cycles(2);
        chk("late_arg_fire", 32'(firingticks), 32'h77);

        send_byte(8'h05); send_byte(8'hF6);
        wait_cycles(100);
        do_reset();
        chk("rst_phase_pll", {28'd0, phasestep, scanclk, clkswitch, phaseupdown}, 32'b0001);
        chk("rst_phase_sel", 32'(phasecounterselect), 32'd0);
        send_byte(8'h0A);
        wait_cycles(12);
        do_reset();
        b = wr;
        wait_cycles(60);
        chk("rst_tx_stops", 32'(wr - b), 32'd0);
        rd = wr;
        expect_status("status_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
